// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// datapath select codes and the decoded instruction class.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_ALU    = 2'd1;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

  // Exactly one field is set for any opcode.
  typedef struct packed {
    logic r_type;
    logic i_arith;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic ecall;
    logic illegal;
  } inst_class_t;

endpackage

// File: rtl/opcode_decoder.sv
// Maps the 7-bit RV32I major opcode onto a one-hot instruction class.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output inst_class_t class_o
);

  always_comb begin
    class_o = '0;
    case (opcode_i)
      OP_R:      class_o.r_type  = 1'b1;
      OP_IMM:    class_o.i_arith = 1'b1;
      OP_LOAD:   class_o.load    = 1'b1;
      OP_STORE:  class_o.store   = 1'b1;
      OP_BRANCH: class_o.branch  = 1'b1;
      OP_JAL:    class_o.jal     = 1'b1;
      OP_JALR:   class_o.jalr    = 1'b1;
      OP_SYSTEM: class_o.ecall   = 1'b1;
      default:   class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath: sequences IF/ID/EX/MEM/WB,
// stalls on mem_ready and halts on an ECALL that the register file flags.
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       is_halted,
  output logic       is_ecall,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic [2:0] state
);

  state_e      state_q, state_d;
  inst_class_t cls;

  opcode_decoder u_dec (
    .opcode_i (opcode),
    .class_o  (cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // Everything below is gated by reset so strobes drop the moment reset falls.
  always_comb begin
    state_d    = state_q;
    is_ecall   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_SRC_PLUS4;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = WB_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    halted     = 1'b0;
    state      = '0;

    if (reset) begin
      state = state_q;
      case (state_q)
        ST_IF: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          if (mem_ready) state_d = ST_ID;
        end

        ST_ID: begin
          alu_src_b = SRCB_IMM;
          if (cls.ecall) begin
            is_ecall = 1'b1;
            if (is_halted) begin
              state_d = ST_HALT;
            end else begin
              pc_write = 1'b1;
              state_d  = ST_IF;
            end
          end else if (cls.illegal) begin
            pc_write = 1'b1;
            state_d  = ST_IF;
          end else begin
            state_d = ST_EX;
          end
        end

        ST_EX: begin
          state_d = ST_IF;
          if (cls.r_type) begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            state_d   = ST_WB;
          end else if (cls.i_arith) begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = ST_WB;
          end else if (cls.load || cls.store) begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_MEM;
          end else if (cls.branch) begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_BRANCH;
            pc_write  = 1'b1;
            pc_source = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PLUS4;
          end else if (cls.jal) begin
            reg_write  = 1'b1;
            mem_to_reg = WB_PC4;
            pc_write   = 1'b1;
            pc_source  = PC_SRC_ALUOUT;
          end else if (cls.jalr) begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            reg_write  = 1'b1;
            mem_to_reg = WB_PC4;
            pc_write   = 1'b1;
            pc_source  = PC_SRC_ALU;
          end
        end

        ST_MEM: begin
          i_or_d = 1'b1;
          if (cls.load) begin
            mem_read = 1'b1;
            if (mem_ready) state_d = ST_WB;
          end else if (cls.store) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              pc_write = 1'b1;
              state_d  = ST_IF;
            end
          end else begin
            state_d = ST_IF;
          end
        end

        ST_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          mem_to_reg = cls.load ? WB_MDR : WB_ALUOUT;
          state_d    = ST_IF;
        end

        ST_HALT: begin
          halted = 1'b1;
        end

        default: state_d = ST_IF;
      endcase
    end
  end

endmodule
